// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives a req/ack data-memory port and stalls the
// front end while an access is outstanding. It also registers the MEM/WB outputs.
module mem_access_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Mem_WB,
    input  logic        read_En,
    input  logic        write_En,
    input  logic [31:0] DataAddress,
    input  logic [31:0] WriteData,
    input  logic [4:0]  dest,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [1:0]  wb_ctrl,
    output logic [31:0] wb_ReadData,
    output logic [31:0] wb_ALUResult,
    output logic [4:0]  Write_Register,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        hold_we_q, hold_we_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic [1:0]  hold_wb_q, hold_wb_d;
    logic [4:0]  hold_dest_q, hold_dest_d;

    logic [1:0]  wb_ctrl_q, wb_ctrl_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic        bus_err_q, bus_err_d;

    logic        acc, misaligned, at_limit;
    logic        res_load;
    logic        res_we;
    logic [31:0] res_addr;
    logic [1:0]  res_wb;
    logic [4:0]  res_dest;

    always_comb begin
        acc        = read_En | write_En;
        misaligned = acc && (DataAddress[1:0] != 2'b00);
        at_limit   = (cnt_q == CW'(TIMEOUT));

        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_wb_d    = hold_wb_q;
        hold_dest_d  = hold_dest_q;
        bus_err_d    = bus_err_q;

        // Bubble is the default MEM/WB contents.
        wb_ctrl_d  = 2'b00;
        wb_rdata_d = 32'd0;
        wb_alu_d   = 32'd0;
        wb_dest_d  = 5'd0;

        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        stall     = 1'b0;

        res_load = 1'b0;
        res_we   = 1'b0;
        res_addr = 32'd0;
        res_wb   = 2'b00;
        res_dest = 5'd0;

        case (state_q)
            S_IDLE: begin
                if (misaligned) begin
                    bus_err_d = 1'b1;
                end else if (acc) begin
                    mem_req   = 1'b1;
                    mem_we    = write_En;
                    mem_addr  = {DataAddress[31:2], 2'b00};
                    mem_wdata = WriteData;
                    if (mem_ack) begin
                        res_load = 1'b1;
                        res_we   = write_En;
                        res_addr = DataAddress;
                        res_wb   = Mem_WB;
                        res_dest = dest;
                    end else begin
                        stall        = 1'b1;
                        hold_we_d    = write_En;
                        hold_addr_d  = {DataAddress[31:2], 2'b00};
                        hold_wdata_d = WriteData;
                        hold_wb_d    = Mem_WB;
                        hold_dest_d  = dest;
                        cnt_d        = CW'(1);
                        state_d      = S_WAIT;
                    end
                end else begin
                    wb_ctrl_d = Mem_WB;
                    wb_alu_d  = DataAddress;
                    wb_dest_d = dest;
                end
            end
            S_WAIT: begin
                stall = !mem_ack;
                if (!mem_ack && at_limit) begin
                    // Abort: the instruction is dropped and only the error flag survives.
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    mem_req   = 1'b1;
                    mem_we    = hold_we_q;
                    mem_addr  = hold_addr_q;
                    mem_wdata = hold_wdata_q;
                    if (mem_ack) begin
                        res_load = 1'b1;
                        res_we   = hold_we_q;
                        res_addr = hold_addr_q;
                        res_wb   = hold_wb_q;
                        res_dest = hold_dest_q;
                        cnt_d    = '0;
                        state_d  = S_IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (res_load) begin
            wb_ctrl_d  = res_we ? 2'b00 : res_wb;
            wb_rdata_d = res_we ? 32'd0 : mem_rdata;
            wb_alu_d   = res_addr;
            wb_dest_d  = res_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= 32'd0;
            hold_wdata_q <= 32'd0;
            hold_wb_q    <= 2'b00;
            hold_dest_q  <= 5'd0;
            wb_ctrl_q    <= 2'b00;
            wb_rdata_q   <= 32'd0;
            wb_alu_q     <= 32'd0;
            wb_dest_q    <= 5'd0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_wb_q    <= hold_wb_d;
            hold_dest_q  <= hold_dest_d;
            wb_ctrl_q    <= wb_ctrl_d;
            wb_rdata_q   <= wb_rdata_d;
            wb_alu_q     <= wb_alu_d;
            wb_dest_q    <= wb_dest_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign wb_ctrl        = wb_ctrl_q;
    assign wb_ReadData    = wb_rdata_q;
    assign wb_ALUResult   = wb_alu_q;
    assign Write_Register = wb_dest_q;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4): pass-through, fast and slow
// accesses, timeout abort, misaligned access, write-wins decode and reset in WAIT.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  Mem_WB;
    logic        read_En;
    logic        write_En;
    logic [31:0] DataAddress;
    logic [31:0] WriteData;
    logic [4:0]  dest;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [1:0]  wb_ctrl;
    logic [31:0] wb_ReadData;
    logic [31:0] wb_ALUResult;
    logic [4:0]  Write_Register;
    logic        bus_err;

    int n_assert;
    int n_fail;
    int stall_cnt;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .Mem_WB(Mem_WB), .read_En(read_En), .write_En(write_En),
        .DataAddress(DataAddress), .WriteData(WriteData), .dest(dest),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .wb_ctrl(wb_ctrl),
        .wb_ReadData(wb_ReadData), .wb_ALUResult(wb_ALUResult),
        .Write_Register(Write_Register), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Mem_WB = 2'b00; read_En = 1'b0; write_En = 1'b0;
        DataAddress = 32'd0; WriteData = 32'd0; dest = 5'd0; mem_ack = 1'b0;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".wb_ctrl"}, 32'(wb_ctrl), 32'd0);
        chk({tag, ".rdata"}, wb_ReadData, 32'd0);
        chk({tag, ".alu"}, wb_ALUResult, 32'd0);
        chk({tag, ".dest"}, 32'(Write_Register), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        idle_inputs();
        mem_rdata = 32'd0;
        rst = 1'b0;
        step();
        step();
        chk_bubble("reset");
        chk("reset.bus_err", 32'(bus_err), 32'd0);
        chk("reset.req", 32'(mem_req), 32'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        rst = 1'b1;
        step();
        $display("reset: checked");

        // 1: plain ALU op passes through with one cycle of latency
        Mem_WB = 2'b10; DataAddress = 32'h1234; dest = 5'd7;
        #1;
        chk("alu.stall", 32'(stall), 32'd0);
        chk("alu.req", 32'(mem_req), 32'd0);
        step();
        chk("alu.wb_ctrl", 32'(wb_ctrl), 32'h2);
        chk("alu.alu", wb_ALUResult, 32'h1234);
        chk("alu.dest", 32'(Write_Register), 32'd7);
        chk("alu.rdata", wb_ReadData, 32'd0);
        $display("test1 ALU pass-through: wb_ctrl=%b alu=%h dest=%0d", wb_ctrl, wb_ALUResult, Write_Register);

        // 2: load acknowledged in the same cycle
        Mem_WB = 2'b11; read_En = 1'b1; DataAddress = 32'h40; dest = 5'd3;
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("fastld.req", 32'(mem_req), 32'd1);
        chk("fastld.we", 32'(mem_we), 32'd0);
        chk("fastld.addr", mem_addr, 32'h40);
        chk("fastld.stall", 32'(stall), 32'd0);
        step();
        idle_inputs();
        chk("fastld.rdata", wb_ReadData, 32'hDEADBEEF);
        chk("fastld.wb_ctrl", 32'(wb_ctrl), 32'h3);
        chk("fastld.alu", wb_ALUResult, 32'h40);
        chk("fastld.dest", 32'(Write_Register), 32'd3);
        $display("test2 fast load: rdata=%h wb_ctrl=%b", wb_ReadData, wb_ctrl);

        // 3: store acknowledged after three stalled cycles; upstream garbage ignored
        Mem_WB = 2'b10; write_En = 1'b1; DataAddress = 32'h80; WriteData = 32'h55; dest = 5'd9;
        #1;
        chk("st.c0.stall", 32'(stall), 32'd1);
        chk("st.c0.req", 32'(mem_req), 32'd1);
        chk("st.c0.we", 32'(mem_we), 32'd1);
        chk("st.c0.addr", mem_addr, 32'h80);
        chk("st.c0.wdata", mem_wdata, 32'h55);
        for (int i = 1; i <= 2; i++) begin
            step();
            chk_bubble("st.wait");
            Mem_WB = 2'b11; write_En = 1'b0; read_En = 1'b1;
            DataAddress = 32'h998; WriteData = 32'h1; dest = 5'd1;
            #1;
            chk("st.wait.stall", 32'(stall), 32'd1);
            chk("st.wait.req", 32'(mem_req), 32'd1);
            chk("st.wait.we", 32'(mem_we), 32'd1);
            chk("st.wait.addr", mem_addr, 32'h80);
            chk("st.wait.wdata", mem_wdata, 32'h55);
        end
        step();
        chk_bubble("st.c3");
        mem_ack = 1'b1;
        #1;
        chk("st.ack.stall", 32'(stall), 32'd0);
        chk("st.ack.req", 32'(mem_req), 32'd1);
        step();
        idle_inputs();
        chk("st.res.wb_ctrl", 32'(wb_ctrl), 32'd0);
        chk("st.res.rdata", wb_ReadData, 32'd0);
        chk("st.res.alu", wb_ALUResult, 32'h80);
        chk("st.res.dest", 32'(Write_Register), 32'd9);
        chk("st.res.bus_err", 32'(bus_err), 32'd0);
        $display("test3 slow store: wb_ctrl=%b alu=%h dest=%0d", wb_ctrl, wb_ALUResult, Write_Register);

        // 4: load never acknowledged -> five stall cycles then abort
        Mem_WB = 2'b11; read_En = 1'b1; DataAddress = 32'h100; dest = 5'd5;
        stall_cnt = 0;
        for (int k = 0; k <= 4; k++) begin
            #1;
            if (stall === 1'b1) stall_cnt++;
            chk("to.req", 32'(mem_req), (k < 4) ? 32'd1 : 32'd0);
            chk("to.bus_err", 32'(bus_err), 32'd0);
            step();
            idle_inputs();
            chk_bubble("to.bubble");
        end
        chk("to.stall_cycles", 32'(stall_cnt), 32'd5);
        chk("to.bus_err_set", 32'(bus_err), 32'd1);
        #1;
        chk("to.idle.req", 32'(mem_req), 32'd0);
        chk("to.idle.stall", 32'(stall), 32'd0);
        $display("test4 timeout: stall_cycles=%0d bus_err=%b", stall_cnt, bus_err);

        // 5: misaligned load, then read+write decoded as store
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mis.pre.bus_err", 32'(bus_err), 32'd0);
        Mem_WB = 2'b11; read_En = 1'b1; DataAddress = 32'h42; dest = 5'd4;
        #1;
        chk("mis.req", 32'(mem_req), 32'd0);
        chk("mis.stall", 32'(stall), 32'd0);
        step();
        chk("mis.bus_err", 32'(bus_err), 32'd1);
        chk_bubble("mis.bubble");
        Mem_WB = 2'b11; read_En = 1'b1; write_En = 1'b1; DataAddress = 32'h44;
        WriteData = 32'hCAFE; dest = 5'd6; mem_ack = 1'b1;
        #1;
        chk("rw.req", 32'(mem_req), 32'd1);
        chk("rw.we", 32'(mem_we), 32'd1);
        step();
        idle_inputs();
        chk("rw.wb_ctrl", 32'(wb_ctrl), 32'd0);
        chk("rw.alu", wb_ALUResult, 32'h44);
        chk("rw.dest", 32'(Write_Register), 32'd6);
        $display("test5 misaligned/write-wins: bus_err=%b wb_ctrl=%b", bus_err, wb_ctrl);

        // 6: reset while waiting; a late ack must not produce a writeback
        Mem_WB = 2'b11; read_En = 1'b1; DataAddress = 32'h200; dest = 5'd12;
        step();
        idle_inputs();
        #1;
        chk("rstw.wait.req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        #1;
        chk("rstw.req", 32'(mem_req), 32'd0);
        chk("rstw.stall", 32'(stall), 32'd0);
        chk_bubble("rstw.out");
        chk("rstw.bus_err", 32'(bus_err), 32'd0);
        step();
        mem_ack = 1'b0;
        chk_bubble("rstw.late_ack");
        $display("test6 reset in WAIT: req=%b wb_ctrl=%b rdata=%h", mem_req, wb_ctrl, wb_ReadData);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
